// File: rtl/rt_i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler and the users of the
// rt_i2c_timing engine: scheduler state encoding and engine field widths.
package rt_i2c_pkg;

  // Engine field widths (byte count minus one, SCL divider)
  localparam int LEN_W = 16;
  localparam int DIV_W = 6;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_BUSY   = 3'd3,
    ST_ABORT  = 3'd4,
    ST_DONE   = 3'd5
  } rt_state_e;

  // A terminal state is the last cycle of a transaction; the grant drops on its exit edge
  function automatic logic isTerminal(input rt_state_e s);
    return (s == ST_DONE) || (s == ST_ABORT);
  endfunction

endpackage

// File: rtl/rt_i2c_sched_arb.sv
// Combinational round-robin picker. The requester after lastId_i has the
// highest priority, wrapping around so lastId_i itself is considered last.
module rt_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  lastId_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  // Two passes: first the indices above lastId_i, then wrap to the ones at or below it
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid_o && req_i[i] && (i > int'(lastId_i))) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        id_o     = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid_o && req_i[i] && (i <= int'(lastId_i))) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        id_o     = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rt_i2c_sched.sv
// Round-robin transaction scheduler sharing one rt_i2c_timing engine among
// N_REQ requesters. It latches the winner's length/divider, launches the
// engine, retries NAKed bytes and aborts on retry exhaustion or watchdog.
module rt_i2c_sched
  import rt_i2c_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int RETRY_MAX = 3,
  parameter int TMO_W     = 20
) (
  input  logic                      rt_i_clk,
  input  logic                      rt_i_rst_n,
  input  logic [N_REQ-1:0]          rt_i_req,
  input  logic [N_REQ*LEN_W-1:0]    rt_i_req_len,
  input  logic [N_REQ*DIV_W-1:0]    rt_i_req_div,
  output logic [N_REQ-1:0]          rt_o_gnt,
  output logic                      rt_o_done,
  output logic                      rt_o_err,
  output logic [$clog2(N_REQ)-1:0]  rt_o_id,
  output logic                      rt_o_busy,
  output logic                      rt_o_tm_en,
  output logic [LEN_W-1:0]          rt_o_tm_len,
  output logic [DIV_W-1:0]          rt_o_tm_div,
  output logic                      rt_o_tm_nak,
  output logic                      rt_o_tm_rst,
  input  logic                      rt_i_tm_ack_latch,
  input  logic                      rt_i_sda,
  input  logic                      rt_i_tm_ready
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int RTR_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RTR_W-1:0] RETRY_LIM = RTR_W'(RETRY_MAX);
  localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(N_REQ - 1);

  rt_state_e         state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   lastId_q, lastId_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [RTR_W-1:0]  retryCnt_q, retryCnt_d;
  logic [TMO_W-1:0]  wdCnt_q, wdCnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmEn_q, tmEn_d;
  logic              tmNak_q, tmNak_d;
  logic              tmRst_q, tmRst_d;

  logic [N_REQ-1:0]  arbGnt;
  logic [ID_W-1:0]   arbId;
  logic              arbValid;

  logic              ackEv;
  logic              nakEv;
  logic [TMO_W-1:0]  wdNext;
  logic              wdExpire;
  logic              retryExhausted;

  rt_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i    (rt_i_req),
    .lastId_i (lastId_q),
    .gnt_o    (arbGnt),
    .id_o     (arbId),
    .valid_o  (arbValid)
  );

  // Byte-level events from the engine; sda is only meaningful on the ack strobe.
  // The watchdog fires on the BUSY cycle that would bring the counter to all-ones,
  // so a stalled engine is aborted after 2^TMO_W-1 BUSY cycles.
  assign ackEv          = rt_i_tm_ack_latch & ~rt_i_sda;
  assign nakEv          = rt_i_tm_ack_latch &  rt_i_sda;
  assign wdNext         = wdCnt_q + TMO_W'(1);
  assign wdExpire       = ~rt_i_tm_ack_latch && (wdNext == '1);
  assign retryExhausted = nakEv && (retryCnt_q == RETRY_LIM);

  // Next-state and registered-output logic; pulses default low, everything else holds
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    lastId_d   = lastId_q;
    len_d      = len_q;
    div_d      = div_q;
    retryCnt_d = retryCnt_q;
    wdCnt_d    = wdCnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmEn_d     = 1'b0;
    tmNak_d    = 1'b0;
    tmRst_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|rt_i_req) begin
          state_d = ST_ARB;
        end
      end

      ST_ARB: begin
        if (arbValid) begin
          state_d    = ST_LAUNCH;
          gnt_d      = arbGnt;
          id_d       = arbId;
          busy_d     = 1'b1;
          retryCnt_d = '0;
          wdCnt_d    = '0;
          for (int k = 0; k < N_REQ; k++) begin
            if (arbGnt[k]) begin
              len_d = rt_i_req_len[k*LEN_W +: LEN_W];
              div_d = rt_i_req_div[k*DIV_W +: DIV_W];
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LAUNCH: begin
        tmEn_d  = 1'b1;
        state_d = ST_BUSY;
      end

      ST_BUSY: begin
        wdCnt_d = rt_i_tm_ack_latch ? '0 : wdNext;
        if (ackEv) begin
          retryCnt_d = '0;
        end
        if (rt_i_tm_ready) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          lastId_d = id_q;
        end else if (retryExhausted || wdExpire) begin
          state_d  = ST_ABORT;
          err_d    = 1'b1;
          tmRst_d  = 1'b1;
          lastId_d = id_q;
        end else if (nakEv) begin
          retryCnt_d = retryCnt_q + RTR_W'(1);
          tmNak_d    = 1'b1;
        end
      end

      ST_DONE, ST_ABORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (isTerminal(state_q)) begin
      gnt_d  = '0;
      busy_d = 1'b0;
    end
  end

  // State and output registers; reset clears everything without emitting done/err
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      id_q       <= '0;
      lastId_q   <= LAST_RST;
      len_q      <= '0;
      div_q      <= '0;
      retryCnt_q <= '0;
      wdCnt_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmEn_q     <= 1'b0;
      tmNak_q    <= 1'b0;
      tmRst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      id_q       <= id_d;
      lastId_q   <= lastId_d;
      len_q      <= len_d;
      div_q      <= div_d;
      retryCnt_q <= retryCnt_d;
      wdCnt_q    <= wdCnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmEn_q     <= tmEn_d;
      tmNak_q    <= tmNak_d;
      tmRst_q    <= tmRst_d;
    end
  end

  assign rt_o_gnt    = gnt_q;
  assign rt_o_done   = done_q;
  assign rt_o_err    = err_q;
  assign rt_o_id     = id_q;
  assign rt_o_busy   = busy_q;
  assign rt_o_tm_en  = tmEn_q;
  assign rt_o_tm_len = len_q;
  assign rt_o_tm_div = div_q;
  assign rt_o_tm_nak = tmNak_q;
  assign rt_o_tm_rst = tmRst_q;

endmodule

// File: tb/tb_rt_i2c_sched.sv
// Self-checking bench for rt_i2c_sched: a small engine model drives ack strobes
// and ready pulses, and a high-level model predicts grant order and outcomes.
module tb_rt_i2c_sched;

  localparam int N         = 4;
  localparam int RETRY_MAX = 3;
  localparam int TMO_W     = 6;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  reqIn;
  logic [15:0] lenIn [N];
  logic [5:0]  divIn [N];
  logic [63:0] lenBus;
  logic [23:0] divBus;
  logic        ackLatch;
  logic        sdaIn;
  logic        tmReady;

  logic [3:0]  gnt;
  logic        done;
  logic        err;
  logic [1:0]  id;
  logic        busy;
  logic        tmEn;
  logic [15:0] tmLen;
  logic [5:0]  tmDiv;
  logic        tmNak;
  logic        tmRst;

  int checkCount  = 0;
  int passCount   = 0;
  int failCount   = 0;
  int nakCount    = 0;
  int enCount     = 0;
  int lastIdModel = N - 1;
  bit sdaSeq[$];

  rt_i2c_sched #(
    .N_REQ     (N),
    .RETRY_MAX (RETRY_MAX),
    .TMO_W     (TMO_W)
  ) dut (
    .rt_i_clk          (clk),
    .rt_i_rst_n        (rstN),
    .rt_i_req          (reqIn),
    .rt_i_req_len      (lenBus),
    .rt_i_req_div      (divBus),
    .rt_o_gnt          (gnt),
    .rt_o_done         (done),
    .rt_o_err          (err),
    .rt_o_id           (id),
    .rt_o_busy         (busy),
    .rt_o_tm_en        (tmEn),
    .rt_o_tm_len       (tmLen),
    .rt_o_tm_div       (tmDiv),
    .rt_o_tm_nak       (tmNak),
    .rt_o_tm_rst       (tmRst),
    .rt_i_tm_ack_latch (ackLatch),
    .rt_i_sda          (sdaIn),
    .rt_i_tm_ready     (tmReady)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge
  always #5 clk = ~clk;

  // Pack the per-requester length/divider arrays onto the flat buses
  always_comb begin
    lenBus = '0;
    divBus = '0;
    for (int k = 0; k < N; k++) begin
      lenBus[k*16 +: 16] = lenIn[k];
      divBus[k*6 +: 6]   = divIn[k];
    end
  end

  // Count engine-facing pulses so spurious or missing ones show up per transaction
  always @(posedge clk) begin
    if (tmNak === 1'b1) nakCount <= nakCount + 1;
    if (tmEn === 1'b1)  enCount  <= enCount + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_gnt"},    32'(gnt),   0);
    checkOutput({pfx, "_done"},   32'(done),  0);
    checkOutput({pfx, "_err"},    32'(err),   0);
    checkOutput({pfx, "_id"},     32'(id),    0);
    checkOutput({pfx, "_busy"},   32'(busy),  0);
    checkOutput({pfx, "_tm_en"},  32'(tmEn),  0);
    checkOutput({pfx, "_tm_len"}, 32'(tmLen), 0);
    checkOutput({pfx, "_tm_div"}, 32'(tmDiv), 0);
    checkOutput({pfx, "_tm_nak"}, 32'(tmNak), 0);
    checkOutput({pfx, "_tm_rst"}, 32'(tmRst), 0);
  endtask

  // Drive a request vector with fresh random length/divider for every requester
  task automatic applyStimulus(input logic [3:0] req);
    reqIn = req;
    for (int k = 0; k < N; k++) begin
      lenIn[k] = 16'($urandom);
      divIn[k] = 6'($urandom);
    end
  endtask

  // Random per-strobe SDA pattern: 1 means the slave NAKed that ack slot
  task automatic makeSeq(input int maxLen, input int nakPct);
    int n;
    sdaSeq.delete();
    n = $urandom_range(maxLen, 1);
    for (int i = 0; i < n; i++) sdaSeq.push_back($urandom_range(99, 0) < nakPct);
  endtask

  // Reference arbiter: scan circularly starting just after the last served requester
  function automatic int modelPick();
    for (int step = 1; step <= N; step++) begin
      if (reqIn[(lastIdModel + step) % N]) return (lastIdModel + step) % N;
    end
    return -1;
  endfunction

  // One full transaction from IDLE: grant timing, launch, engine strobes, and the ending
  task automatic runTransaction(input bit dropAfter, input bit stall, output int gotId);
    int          expId, expNaks, abortAt, run, nakBase, enBase, n;
    logic [15:0] expLen;
    logic [5:0]  expDiv;
    expId  = modelPick();
    expLen = lenIn[expId];
    expDiv = divIn[expId];
    // A byte may be NAKed RETRY_MAX times; the next consecutive NAK on it aborts
    expNaks = 0;
    abortAt = -1;
    run     = 0;
    for (int i = 0; i < sdaSeq.size(); i++) begin
      if (abortAt < 0) begin
        if (sdaSeq[i]) begin
          run++;
          if (run > RETRY_MAX) abortAt = i;
          else expNaks++;
        end else begin
          run = 0;
        end
      end
    end
    nakBase = nakCount;
    enBase  = enCount;

    tick();
    checkOutput("arb_no_gnt_yet", 32'(gnt), 0);
    tick();
    gotId = int'(id);
    checkOutput("gnt_onehot", 32'(gnt),   32'(1) << expId);
    checkOutput("gnt_id",     32'(id),    32'(expId));
    checkOutput("gnt_busy",   32'(busy),  1);
    checkOutput("gnt_tm_len", 32'(tmLen), 32'(expLen));
    checkOutput("gnt_tm_div", 32'(tmDiv), 32'(expDiv));
    tick();
    checkOutput("launch_tm_en", 32'(tmEn), 1);

    // Inputs after arbitration must have no effect on the running transfer
    for (int k = 0; k < N; k++) begin
      lenIn[k] = 16'($urandom);
      divIn[k] = 6'($urandom);
    end
    if (dropAfter) reqIn = 4'($urandom);

    if (stall) begin
      n = 0;
      while (err !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      checkOutput("wdog_busy_cycles", 32'(n), 63);
      checkOutput("wdog_tm_rst", 32'(tmRst), 1);
      abortAt = 0;
    end else begin
      for (int i = 0; i < sdaSeq.size() && (abortAt < 0 || i <= abortAt); i++) begin
        repeat ($urandom_range(3, 0)) tick();
        ackLatch = 1'b1;
        sdaIn    = sdaSeq[i];
        tick();
        ackLatch = 1'b0;
        sdaIn    = 1'($urandom);
        if (i == abortAt) begin
          checkOutput("abort_err",    32'(err),   1);
          checkOutput("abort_tm_rst", 32'(tmRst), 1);
          checkOutput("abort_no_nak", 32'(tmNak), 0);
          checkOutput("abort_id",     32'(id),    32'(expId));
        end else begin
          checkOutput("nak_pulse", 32'(tmNak), 32'(sdaSeq[i]));
        end
      end
    end

    if (abortAt >= 0) begin
      if (dropAfter) reqIn = '0;
      tick();
      checkOutput("abort_gnt_clr",  32'(gnt),   0);
      checkOutput("abort_busy_clr", 32'(busy),  0);
      checkOutput("abort_err_1cyc", 32'(err),   0);
      checkOutput("abort_rst_1cyc", 32'(tmRst), 0);
    end else begin
      repeat ($urandom_range(3, 0)) tick();
      tmReady = 1'b1;
      tick();
      tmReady = 1'b0;
      checkOutput("done_pulse",  32'(done),  1);
      checkOutput("done_no_err", 32'(err),   0);
      checkOutput("done_id",     32'(id),    32'(expId));
      checkOutput("done_tm_len", 32'(tmLen), 32'(expLen));
      checkOutput("done_tm_div", 32'(tmDiv), 32'(expDiv));
      if (dropAfter) reqIn = '0;
      tick();
      checkOutput("done_gnt_clr",  32'(gnt),  0);
      checkOutput("done_1cyc",     32'(done), 0);
      checkOutput("done_busy_clr", 32'(busy), 0);
    end
    lastIdModel = expId;
    checkOutput("nak_pulse_total", 32'(nakCount - nakBase), 32'(expNaks));
    checkOutput("tm_en_total",     32'(enCount - enBase),   1);
  endtask

  // Directed sequence: reset, single request, NAK handling, watchdog, random mix,
  // reset mid-transfer, then fairness with all requesters held
  initial begin
    int gotId;
    rstN     = 1'b0;
    ackLatch = 1'b0;
    sdaIn    = 1'b0;
    tmReady  = 1'b0;
    applyStimulus(4'b0000);
    repeat (3) tick();
    checkAllZero("reset");
    rstN = 1'b1;
    tick();

    $display("[TB] single request on requester 2");
    applyStimulus(4'b0100);
    lenIn[2] = 16'h0000;
    divIn[2] = 6'd4;
    sdaSeq   = '{1'b0};
    runTransaction(1'b1, 1'b0, gotId);

    $display("[TB] NAK then ACK, retry budget restored by ACK");
    applyStimulus(4'b1001);
    sdaSeq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    runTransaction(1'b1, 1'b0, gotId);

    $display("[TB] retry exhaustion");
    applyStimulus(4'($urandom_range(15, 1)));
    sdaSeq = '{1'b1, 1'b1, 1'b1, 1'b1};
    runTransaction(1'b1, 1'b0, gotId);

    $display("[TB] watchdog on stalled engine");
    applyStimulus(4'($urandom_range(15, 1)));
    sdaSeq.delete();
    runTransaction(1'b1, 1'b1, gotId);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 6; t++) begin
      applyStimulus(4'($urandom_range(15, 1)));
      makeSeq(6, 40);
      runTransaction(1'b1, 1'b0, gotId);
    end

    $display("[TB] reset during BUSY");
    applyStimulus(4'b1000);
    tick();
    tick();
    checkOutput("prerst_gnt", 32'(gnt), 32'(1) << modelPick());
    tick();
    tick();
    #2 rstN = 1'b0;
    #1 checkAllZero("midrst");
    reqIn = '0;
    tick();
    tick();
    checkOutput("midrst_no_done", 32'(done), 0);
    checkOutput("midrst_no_err",  32'(err),  0);
    lastIdModel = N - 1;
    applyStimulus(4'b1111);
    rstN = 1'b1;

    $display("[TB] fairness with all requesters held");
    for (int t = 0; t < 8; t++) begin
      makeSeq(3, 20);
      runTransaction(1'b0, 1'b0, gotId);
      checkOutput("fair_order", 32'(gotId), 32'(t % N));
    end

    reqIn = '0;
    tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
